// File: rtl/mux8_scan_pkg.sv
// Shared types and helpers for the 8-channel mux scan controller.
// States, channel-index width and the next-set-bit search used by the scan sequencer.
package mux8_scan_pkg;

    localparam int NCH  = 8;
    localparam int IDXW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_CAPT = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
    } next_t;

    // Lowest set bit strictly above ch; found=0 when none remains, so the scan never wraps.
    function automatic next_t next_set(input logic [NCH-1:0] mask, input logic [IDXW-1:0] ch);
        next_t res;
        res.found = 1'b0;
        res.idx   = {IDXW{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            if ((i > int'(ch)) && mask[i]) begin
                res.found = 1'b1;
                res.idx   = IDXW'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux8_prio_next.sv
// Combinational next-channel finder for the scan sequencer.
// In first mode bit 0 is eligible; otherwise only bits above ch are searched.
module mux8_prio_next
    import mux8_scan_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [IDXW-1:0] ch,
    input  logic            first,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    next_t nx_s;

    // Select bit 0 directly for a fresh scan, else take the next higher set bit.
    always_comb begin
        nx_s = next_set(mask, ch);
        if (first && mask[0]) begin
            found = 1'b1;
            idx   = {IDXW{1'b0}};
        end else begin
            found = nx_s.found;
            idx   = nx_s.idx;
        end
    end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Sequential front-end for the 8:1 mux tree: walks enabled channels, samples, hands off.
// Optional MUX_SCAN_SUM_EN adds the sum_out accumulator of captured words.
module mux8_scan_ctrl
    import mux8_scan_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = mux8_scan_pkg::NCH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [WIDTH-1:0] mux_data,
    output logic             sel_1,
    output logic             sel_2,
    output logic             sel_3,
    output logic [WIDTH-1:0] data_out,
    output logic [IDXW-1:0]  ch_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             busy,
    output logic             done
`ifdef MUX_SCAN_SUM_EN
    ,
    output logic [WIDTH+2:0] sum_out
`endif
);

    state_t          state_r, state_n_s;
    logic [IDXW-1:0] ch_r, ch_n_s;
    logic [NCH-1:0]  mask_r;
    logic [NCH-1:0]  prio_mask_s;
    logic [IDXW-1:0] prio_ch_s;
    logic            prio_first_s;
    logic [IDXW-1:0] nxt_idx_s;
    logic            nxt_found_s;
    logic            mask_load_s, capt_s, clr_valid_s, done_n_s, sum_clr_s;

    // In IDLE search the live request mask from bit 0; afterwards search the latched mask.
    always_comb begin
        if (state_r == ST_IDLE) begin
            prio_mask_s  = ch_mask;
            prio_ch_s    = {IDXW{1'b0}};
            prio_first_s = 1'b1;
        end else begin
            prio_mask_s  = mask_r;
            prio_ch_s    = ch_r;
            prio_first_s = 1'b0;
        end
    end

    mux8_prio_next u_prio (
        .mask  (prio_mask_s),
        .ch    (prio_ch_s),
        .first (prio_first_s),
        .idx   (nxt_idx_s),
        .found (nxt_found_s)
    );

    // Next-state and control strobes.
    always_comb begin
        state_n_s   = state_r;
        ch_n_s      = ch_r;
        mask_load_s = 1'b0;
        capt_s      = 1'b0;
        clr_valid_s = 1'b0;
        done_n_s    = 1'b0;
        sum_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sum_clr_s = 1'b1;
                    if (nxt_found_s) begin
                        mask_load_s = 1'b1;
                        ch_n_s      = nxt_idx_s;
                        state_n_s   = ST_SEL;
                    end else begin
                        done_n_s = 1'b1;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_SEL:  state_n_s = ST_CAPT;
            ST_CAPT: begin
                capt_s    = 1'b1;
                state_n_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (valid_out && ready_in) begin
                    clr_valid_s = 1'b1;
                    if (nxt_found_s) begin
                        ch_n_s    = nxt_idx_s;
                        state_n_s = ST_SEL;
                    end else begin
                        done_n_s  = 1'b1;
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State, channel, latched mask and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ch_r      <= {IDXW{1'b0}};
            mask_r    <= {NCH{1'b0}};
            data_out  <= {WIDTH{1'b0}};
            ch_out    <= {IDXW{1'b0}};
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r <= state_n_s;
            ch_r    <= ch_n_s;
            busy    <= (state_n_s != ST_IDLE);
            done    <= done_n_s;
            if (mask_load_s) begin
                mask_r <= ch_mask;
            end
            if (capt_s) begin
                data_out  <= mux_data;
                ch_out    <= ch_r;
                valid_out <= 1'b1;
            end else if (clr_valid_s) begin
                valid_out <= 1'b0;
            end
        end
    end

    // Selects come straight from the channel register, so they move only when SEL is entered.
    assign sel_1 = ch_r[0];
    assign sel_2 = ch_r[1];
    assign sel_3 = ch_r[2];

`ifdef MUX_SCAN_SUM_EN
    // Running sum of captured words; three guard bits cover eight full-scale samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out <= {(WIDTH+3){1'b0}};
        end else if (sum_clr_s) begin
            sum_out <= {(WIDTH+3){1'b0}};
        end else if (capt_s) begin
            sum_out <= sum_out + {3'b000, mux_data};
        end else begin
            sum_out <= sum_out;
        end
    end
`endif

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Scoreboard bench for mux8_scan_ctrl with a behavioural 8:1 mux tree around it.
module tb_mux8_scan_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  ch_mask;
    logic [15:0] mux_data;
    logic        sel_1, sel_2, sel_3;
    logic [15:0] data_out;
    logic [2:0]  ch_out;
    logic        valid_out;
    logic        ready_in;
    logic        busy;
    logic        done;
`ifdef MUX_SCAN_SUM_EN
    logic [18:0] sum_out;
`endif

    logic [15:0] in_val [8];
    exp_t        exp_q [$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          stall_ch = -1;
    int          stall_left = 0;
    logic        force_low = 1'b0;

    assign mux_data = in_val[{sel_3, sel_2, sel_1}];

    always #5 clk = ~clk;

    mux8_scan_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ch_mask   (ch_mask),
        .mux_data  (mux_data),
        .sel_1     (sel_1),
        .sel_2     (sel_2),
        .sel_3     (sel_3),
        .data_out  (data_out),
        .ch_out    (ch_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .busy      (busy),
        .done      (done)
`ifdef MUX_SCAN_SUM_EN
        ,
        .sum_out   (sum_out)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: held low on request or while a chosen channel is being stalled.
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (force_low) begin
                ready_in = 1'b0;
            end else if (valid_out && stall_ch >= 0 && int'(ch_out) == stall_ch && stall_left > 0) begin
                ready_in = 1'b0;
                stall_left--;
            end else begin
                ready_in = 1'b1;
            end
        end
    end

    // Monitor: pop on every handshake, check stability across stalls, count done pulses.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        logic [2:0]  prev_ch;
        logic [2:0]  prev_sel;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = 16'h0000;
        prev_ch    = 3'd0;
        prev_sel   = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, valid_out}, 32'd1);
                    chk("stall_data", {16'd0, data_out}, {16'd0, prev_data});
                    chk("stall_ch", {29'd0, ch_out}, {29'd0, prev_ch});
                    chk("stall_sel", {29'd0, sel_3, sel_2, sel_1}, {29'd0, prev_sel});
                end
                if (valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {13'd0, ch_out, data_out}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", {16'd0, data_out}, {16'd0, e.data});
                        chk("word_ch", {29'd0, ch_out}, {29'd0, e.ch});
                        chk("word_sel", {29'd0, sel_3, sel_2, sel_1}, {29'd0, e.ch});
                    end
                end
                prev_stall = valid_out && !ready_in;
                prev_data  = data_out;
                prev_ch    = ch_out;
                prev_sel   = {sel_3, sel_2, sel_1};
                if (done) begin
                    done_cnt++;
                end
            end
        end
    end

    // Issue one scan, optionally stalling a channel or re-pulsing start mid-scan.
    task automatic run_scan(input logic [7:0] mask, input int exp_edges, input int stall_c,
                            input int restart_at);
        int   edges;
        int   first_valid;
        int   dcnt;
        exp_t e;
        for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
                e.data = in_val[c];
                e.ch   = 3'(c);
                exp_q.push_back(e);
            end
        end
        stall_ch    = stall_c;
        stall_left  = 5;
        first_valid = 0;
        dcnt        = done_cnt;
        @(posedge clk);
        #1;
        ch_mask = mask;
        start   = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        start   = 1'b0;
        ch_mask = ~mask;
        forever begin
            @(negedge clk);
            if (edges == 1) begin
                chk("busy_after_start", {31'd0, busy}, {31'd0, (mask != 8'h00)});
            end
            if (valid_out && first_valid == 0) begin
                first_valid = edges;
            end
            if (done) begin
                break;
            end
            if (edges > 400) begin
                chk("scan_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            edges++;
            #1;
            start   = (edges == restart_at);
            ch_mask = (edges == restart_at) ? 8'hFF : ~mask;
        end
        chk("scan_edges", 32'(edges), 32'(exp_edges));
        chk("first_valid", 32'(first_valid), (mask != 8'h00) ? 32'd3 : 32'd0);
        @(negedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("done_count", 32'(done_cnt), 32'(dcnt + 1));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        stall_ch = -1;
    endtask

    initial begin
        int dcnt;
        rst_n   = 1'b0;
        start   = 1'b0;
        ch_mask = 8'h00;
        for (int k = 0; k < 8; k++) begin
            in_val[k] = 16'h1000 + 16'(k + 1);
        end
        #12;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", {16'd0, data_out}, 32'd0);
        chk("rst_ch", {29'd0, ch_out}, 32'd0);
        chk("rst_sel", {29'd0, sel_3, sel_2, sel_1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full mask: eight words, three cycles each.
        run_scan(8'hFF, 25, -1, 0);
`ifdef MUX_SCAN_SUM_EN
        chk("sum_full_seq", 32'(sum_out), 32'h0000_8024);
`endif
        // Sparse mask: channels 2, 5, 7 only.
        run_scan(8'b1010_0100, 10, -1, 0);
        // Stall ch 5 for five cycles, and a start pulse that must be ignored.
        run_scan(8'b1010_0100, 15, 5, 5);
        // Empty mask: done only.
        run_scan(8'h00, 1, -1, 0);

        // Reset while waiting on a handshake.
        force_low = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_q.push_back({in_val[c], 3'(c)});
        end
        @(posedge clk);
        #1;
        ch_mask = 8'hFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (valid_out) begin
                break;
            end
        end
        chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, valid_out}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_data", {16'd0, data_out}, 32'd0);
        chk("async_sel", {29'd0, sel_3, sel_2, sel_1}, 32'd0);
        exp_q.delete();
        dcnt = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        force_low = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt), 32'(dcnt));
        chk("idle_after_rst", {31'd0, busy}, 32'd0);
        run_scan(8'b1010_0100, 10, -1, 0);

`ifdef MUX_SCAN_SUM_EN
        for (int k = 0; k < 8; k++) begin
            in_val[k] = 16'hFFFF;
        end
        run_scan(8'hFF, 25, -1, 0);
        chk("sum_full_scale", 32'(sum_out), 32'h0007_FFF8);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
